// File: rtl/nand2_stim_pkg.sv
`timescale 1ps/1fs
// nand2_stim_pkg: shared state type, vector table, LFSR constants and the
// resistive-drive descriptor used by the NAND2 stimulus generator.
package nand2_stim_pkg;

   // Run sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Resistive drive descriptor: source level in microvolts behind a series
   // resistance in ohms. A resistance of RES_INF means the path is open.
   typedef struct packed {
      logic signed [31:0] v;
      logic        [31:0] r;
   } xreal;

   localparam logic [31:0] RES_INF = 32'hFFFF_FFFF;

   // {A,B} Gray order: 00, 01, 11, 10 (entry 0 is the rightmost element)
   localparam logic [3:0][1:0] GRAY_TBL = {2'b10, 2'b11, 2'b01, 2'b00};

   // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bit positions 7,5,4,3
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   // Shift left, feeding the tap parity into bit 0
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   // Series resistance sum that saturates at the open-circuit value
   function automatic logic [31:0] res_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum >= {1'b0, RES_INF}) ? RES_INF : sum[31:0];
   endfunction

endpackage

// File: rtl/stim_drv_RC.sv
`timescale 1ps/1fs
// stim_drv_RC: converts one logic bit into a resistive drive. A pull-up switch
// of RDRV ohms (in series with the supply's own resistance) connects to VDD
// when din=1; a pull-down switch of RDRV ohms connects to ground when din=0.
module stim_drv_RC
   import nand2_stim_pkg::*;
#(
   parameter real RDRV = 1e3
) (
   input  logic din,
   input  xreal vdd,
   output xreal dout
);

   localparam logic [31:0] R_OHM = 32'($rtoi(RDRV));

   logic [31:0] r_up;
   logic [31:0] r_dn;

   // Close exactly one switch; the open path reads as infinite resistance
   always_comb begin
      r_up = RES_INF;
      r_dn = RES_INF;
      if (din) begin
         r_up = res_add(R_OHM, vdd.r);
      end else begin
         r_dn = R_OHM;
      end
   end

   // Collapse the two switch paths into one source level and series resistance
   always_comb begin
      dout.v = '0;
      dout.r = r_dn;
      if (r_up != RES_INF) begin
         dout.v = vdd.v;
         dout.r = r_up;
      end
   end

endmodule

// File: rtl/nand2_stim_gen.sv
`timescale 1ps/1fs
// nand2_stim_gen: steps a 2-input gate through {A,B} = 00,01,11,10, holding
// each vector HOLD_CYC cycles, for N_LOOPS passes per run, and drives A/B as
// resistive analog outputs through stim_drv_RC.
// Optional feature: define NAND2_STIM_LFSR_EN to add the 'mode' input, which
// selects vectors from an 8-bit LFSR instead of the Gray table.
module nand2_stim_gen
   import nand2_stim_pkg::*;
#(
   parameter int unsigned HOLD_CYC = 8,
   parameter int unsigned N_LOOPS  = 1,
   parameter real         RDRV     = 1e3
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
`ifdef NAND2_STIM_LFSR_EN
   input  logic       mode,
`endif
   input  xreal       VDD,
   output xreal       A,
   output xreal       B,
   output logic       busy,
   output logic       done,
   output logic [1:0] vec_idx
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);
   localparam logic [3:0] LOOP_LAST = 4'(N_LOOPS - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] hold_cnt;
   logic [7:0] hold_nxt;
   logic [1:0] vec_cnt;
   logic [1:0] vec_nxt;
   logic [1:0] vec_inc;
   logic [3:0] loop_cnt;
   logic [3:0] loop_nxt;
   logic [1:0] ab;        // registered logic levels {A,B}
   logic [1:0] ab_nxt;
   logic [1:0] first_ab;  // vector applied on the first RUN cycle
   logic [1:0] step_ab;   // vector applied after a hold period expires
`ifdef NAND2_STIM_LFSR_EN
   logic [7:0] lfsr;
   logic [7:0] lfsr_nxt;
   logic [7:0] lfsr_adv;
`endif

   assign vec_inc = vec_cnt + 2'd1;

`ifdef NAND2_STIM_LFSR_EN
   // Vector source: Gray table, or low LFSR bits when mode=1
   always_comb begin
      lfsr_adv = lfsr_next(lfsr);
      first_ab = mode ? LFSR_SEED[1:0] : GRAY_TBL[0];
      step_ab  = mode ? lfsr_adv[1:0]  : GRAY_TBL[vec_inc];
   end
`else
   // Vector source: Gray table
   always_comb begin
      first_ab = GRAY_TBL[0];
      step_ab  = GRAY_TBL[vec_inc];
   end
`endif

   // Next-state and counter update; start is only looked at in IDLE
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      vec_nxt   = vec_cnt;
      loop_nxt  = loop_cnt;
      ab_nxt    = ab;
`ifdef NAND2_STIM_LFSR_EN
      lfsr_nxt  = lfsr;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               hold_nxt  = '0;
               vec_nxt   = '0;
               loop_nxt  = '0;
               ab_nxt    = first_ab;
`ifdef NAND2_STIM_LFSR_EN
               lfsr_nxt  = LFSR_SEED;
`endif
            end
         end
         RUN: begin
            if (hold_cnt == HOLD_LAST) begin
               hold_nxt = '0;
`ifdef NAND2_STIM_LFSR_EN
               lfsr_nxt = lfsr_adv;
`endif
               if ((vec_cnt == 2'd3) && (loop_cnt == LOOP_LAST)) begin
                  // last vector of the last pass: finish instead of wrapping
                  state_nxt = DONE;
                  vec_nxt   = '0;
                  loop_nxt  = '0;
                  ab_nxt    = '0;
               end else begin
                  vec_nxt = vec_inc;
                  ab_nxt  = step_ab;
                  if (vec_cnt == 2'd3) begin
                     loop_nxt = loop_cnt + 4'd1;
                  end
               end
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            ab_nxt    = '0;
         end
      endcase
   end

   // State, counters and registered A/B levels; reset aborts any run at once
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         hold_cnt <= '0;
         vec_cnt  <= '0;
         loop_cnt <= '0;
         ab       <= '0;
`ifdef NAND2_STIM_LFSR_EN
         lfsr     <= LFSR_SEED;
`endif
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         vec_cnt  <= vec_nxt;
         loop_cnt <= loop_nxt;
         ab       <= ab_nxt;
`ifdef NAND2_STIM_LFSR_EN
         lfsr     <= lfsr_nxt;
`endif
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

`ifdef NAND2_STIM_LFSR_EN
   assign vec_idx = mode ? ab : vec_cnt;
`else
   assign vec_idx = vec_cnt;
`endif

   stim_drv_RC #(.RDRV(RDRV)) u_drv_a (
      .din  (ab[1]),
      .vdd  (VDD),
      .dout (A)
   );

   stim_drv_RC #(.RDRV(RDRV)) u_drv_b (
      .din  (ab[0]),
      .vdd  (VDD),
      .dout (B)
   );

endmodule

// File: tb/tb_nand2_stim_gen.sv
`timescale 1ps/1fs
// tb_nand2_stim_gen: directed bench for nand2_stim_gen with an RC load model
// on output A of the HOLD_CYC=2 / N_LOOPS=1 instance.
module tb_nand2_stim_gen;
   import nand2_stim_pkg::*;

   localparam real CLOAD = 10e-15;  // farads
   localparam real TSTEP = 0.1;     // ps, load model step

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic       start3;
   logic       mode;
   xreal       vdd;
   xreal       a_out, b_out, a3, b3;
   logic       busy, done, busy3, done3;
   logic [1:0] vec_idx, vec3;
   logic       a_bit, b_bit;

   int  n_chk = 0;
   int  n_fail = 0;
   int  done_cnt = 0;
   real a_node = 0.0;
   real t_edge = 0.0;
   real t_rise = -1.0;

   logic [5:0] exp1 [12] = '{6'b100000, 6'b100000, 6'b100101, 6'b100101,
                             6'b101011, 6'b101011, 6'b101110, 6'b101110,
                             6'b010000, 6'b000000, 6'b000000, 6'b000000};
   logic [1:0] lfsr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [3:0] e3;
   int         blen;
   bit         seen;
   int         done_before;

   assign a_bit = (a_out.v != 0);
   assign b_bit = (b_out.v != 0);

   always #500 clk = ~clk;

   nand2_stim_gen #(.HOLD_CYC(2), .N_LOOPS(1), .RDRV(1e3)) u_dut (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start),
`ifdef NAND2_STIM_LFSR_EN
      .mode    (mode),
`endif
      .VDD     (vdd),
      .A       (a_out),
      .B       (b_out),
      .busy    (busy),
      .done    (done),
      .vec_idx (vec_idx)
   );

   nand2_stim_gen #(.HOLD_CYC(1), .N_LOOPS(3), .RDRV(1e3)) u_dut3 (
      .clk     (clk),
      .rstn    (rstn),
      .start   (start3),
`ifdef NAND2_STIM_LFSR_EN
      .mode    (mode),
`endif
      .VDD     (vdd),
      .A       (a3),
      .B       (b3),
      .busy    (busy3),
      .done    (done3),
      .vec_idx (vec3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Exact exponential step of a node charged through the drive resistance
   function automatic real rc_step(input real v, input xreal d);
      real vt;
      real tau;
      if (d.r == RES_INF) return v;
      vt = real'(d.v) / 1.0e6;
      if (d.r == 0) return vt;
      tau = real'(d.r) * CLOAD * 1.0e12;
      return vt + (v - vt) * $exp(-TSTEP / tau);
   endfunction

   always @(posedge clk) t_edge = $realtime;

   always @(negedge clk) if (done) done_cnt++;

   // Load model on A; records delay of each upward 0.5 V crossing from the last clk edge
   initial begin
      real prev;
      forever begin
         #(TSTEP);
         prev = a_node;
         a_node = rc_step(a_node, a_out);
         if (prev < 0.5 && a_node >= 0.5) t_rise = $realtime - t_edge;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vdd.v  = 32'sd1_000_000;
      vdd.r  = '0;
      rstn   = 1'b0;
      start  = 1'b0;
      start3 = 1'b0;
      mode   = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_vec", vec_idx, 0);
      chk("rst_a_v", a_out.v, 0);
      chk("rst_a_r", a_out.r, 1000);
      chk("rst_b_r", b_out.r, 1000);
      chk("rst_busy3", busy3, 0);
      rstn = 1'b1;

      // run 1: HOLD_CYC=2, a second start pulse lands mid-run
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         if (k > 0) @(negedge clk);
         start = (k == 3);
         chk($sformatf("run1_k%0d", k), {26'd0, busy, done, vec_idx, a_bit, b_bit},
             {26'd0, exp1[k]});
      end
      chk($sformatf("rc_t50_%0.3fps", t_rise), (t_rise >= 6.585 && t_rise <= 7.278), 1);
      chk("a_high_r", a_out.r, 1000);

      // run 3: HOLD_CYC=1, N_LOOPS=3
      @(negedge clk) start3 = 1'b1;
      @(negedge clk) start3 = 1'b0;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(negedge clk);
         e3 = (k < 12) ? {2'b10, 2'(k % 4)} : ((k == 12) ? 4'b0100 : 4'b0000);
         chk($sformatf("run3_k%0d", k), {28'd0, busy3, done3, vec3}, {28'd0, e3});
      end

      // abort: reset mid-run while A is high
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_a_before", a_bit, 1);
      done_before = done_cnt;
      #200 rstn = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_vec", vec_idx, 0);
      chk("abort_a_logic", a_bit, 0);
      #49;
      chk("abort_decay", (a_node < 0.1), 1);
      repeat (3) @(negedge clk);
      chk("abort_no_done", done_cnt, done_before);

      // release with start already high, hold start through the run
      @(negedge clk);
      start = 1'b1;
      rstn  = 1'b1;
      @(negedge clk);
      chk("rel_busy", busy, 1);
      blen = 0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (busy) blen++;
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      chk("held_done_seen", seen, 1);
      chk("held_run_len", blen, 8);
      @(negedge clk);
      chk("retrig_idle", {busy, done}, 2'b00);
      @(negedge clk);
      chk("retrig_run", busy, 1);
      start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("retrig_done_seen", seen, 1);
      @(negedge clk);
      chk("final_idle", busy, 0);

`ifdef NAND2_STIM_LFSR_EN
      // LFSR vectors, two runs from the same seed
      mode = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         @(negedge clk) start = 1'b1;
         @(negedge clk) start = 1'b0;
         for (int s = 0; s < 4; s++) begin
            chk($sformatf("lfsr_r%0d_s%0d_ab", rep, s), {a_bit, b_bit}, lfsr_exp[s]);
            chk($sformatf("lfsr_r%0d_s%0d_idx", rep, s), vec_idx, lfsr_exp[s]);
            repeat (2) @(negedge clk);
         end
         chk($sformatf("lfsr_r%0d_done", rep), done, 1);
         @(negedge clk);
      end
      mode = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/nand2_stim_gen.md
NAND2_STIM_GEN -- requirements
Module: nand2_stim_gen

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 8: clock cycles each input vector is held; legal range 1..255.
REQ-002 SHALL have parameter N_LOOPS, default 1: number of full vector sequences per run; legal range 1..15.
REQ-003 SHALL have parameter real RDRV, default 1e3: driver output resistance in ohms, applied to both rails.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request to begin a run.
REQ-007 SHALL have port VDD, input, xreal: supply level for high outputs.
REQ-008 SHALL have ports A and B, output, xreal: analog stimulus for a downstream 2-input gate.
REQ-009 SHALL have port busy, output, 1 bit: run in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at run completion.
REQ-011 SHALL have port vec_idx, output, 2 bits: index of the vector currently applied.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE with start=1, SHALL enter RUN next cycle with vec_idx=0, hold counter=0 and loop counter=0.
REQ-014 In RUN, the hold counter SHALL increment each cycle; at HOLD_CYC-1 it clears and vec_idx advances.
REQ-015 Vector order SHALL be the Gray sequence {A,B} = 00, 01, 11, 10, so exactly one input toggles per step.
REQ-016 vec_idx 3 wrapping to 0 SHALL increment the loop counter.
REQ-017 When the loop counter reaches N_LOOPS, SHALL go to DONE instead of wrapping.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 start held high in IDLE SHALL retrigger a run the cycle after DONE.
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 Each run SHALL last exactly 4*HOLD_CYC*N_LOOPS cycles with busy=1.
REQ-023 Outside RUN, logical A and B SHALL both be 0.
REQ-024 Each xreal output SHALL be driven through resistance RDRV to VDD when its logic value is 1, or to ground when 0; the opposite path is at INFINITY.
REQ-025 Output edges SHALL therefore follow the RC time constant of RDRV and the downstream load.
REQ-026 Logic A/B changes SHALL be registered, occurring only on clk rising edges.

Reset
REQ-027 rstn=0 SHALL immediately force: state IDLE, all counters 0, busy=0, done=0, vec_idx=0, logic A=B=0 (outputs pulled to ground).
REQ-028 Reset asserted mid-run SHALL abort the run without a done pulse.
REQ-029 After rstn deasserts, start SHALL be sampled from the first rising edge.

Configuration
REQ-030 Macro NAND2_STIM_LFSR_EN, when defined, SHALL add input mode (1 bit).
REQ-031 With NAND2_STIM_LFSR_EN defined and mode=1, each vector step SHALL take {A,B} from bits [1:0] of an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 at reset and at each run start) advanced once per step; vec_idx then reports those bits.
REQ-032 With NAND2_STIM_LFSR_EN defined and mode=0, behaviour SHALL equal the undefined case.
REQ-033 Without NAND2_STIM_LFSR_EN, the mode port and LFSR SHALL not exist.

Structure
REQ-034 Package nand2_stim_pkg SHALL hold the state enum type, the 4-entry Gray vector table and the LFSR seed/tap constants.
REQ-035 Sub-module stim_drv_RC SHALL convert one logic bit to a resistive xreal drive (two switches, RDRV), instanced twice.

Verification
REQ-036 Reset, start=1 for 1 cycle, HOLD_CYC=2, N_LOOPS=1 -> {A,B} = 00,01,11,10 for 2 cycles each; busy high 8 cycles; done pulses once at cycle 9.
REQ-037 N_LOOPS=3, HOLD_CYC=1 -> 12 busy cycles; vec_idx sequence 0,1,2,3 repeated three times; single done pulse.
REQ-038 rstn pulled low at cycle 5 of a run -> busy=0 immediately; A decays to below 0.1*VDD within 5*RDRV*Cload; no done pulse.
REQ-039 start pulsed while busy -> run length unchanged; no second run.
REQ-040 VDD=1.0, RDRV=1e3, 10 fF load, A rising -> A crosses 0.5 V 6.9 ps +/- 5% after the clk edge.
REQ-041 NAND2_STIM_LFSR_EN defined, mode=1 -> first four {A,B} values match the LFSR model from seed 8'hA5; repeated run gives an identical sequence.
